ctech_lib_clk_gate_ctrl: RTL and testbench
==========================================

Name: ctech_lib_clk_gate_ctrl

Overview:
- Parametrised, multi-channel clock-gating controller; successor to the two-input clock AND primitive.
- Each channel owns a glitch-free latch-based gate on the shared clock.
- Each channel has a per-channel req/ack handshake, a wake-up delay before ack, and a hysteresis idle counter before gating off.
- Sits between power-management logic and leaf clock domains; a test-enable input forces all gates open.

Parameters:
- NUM_CH, 4, number of independently gated output clocks (1..32).
- WAKE_CYC, 2, cycles between gate opening and ack assertion (0..255).
- HYST_CYC, 8, idle cycles with req low before the gate closes (0..255).
- CNT_W, 8, counter width; must satisfy 2**CNT_W > max(WAKE_CYC, HYST_CYC).

Ports:
- clk  input  1  free-running source clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_CH  per-channel clock request, synchronous to clk.
- te  input  1  test enable; forces every gate open, bypasses the FSM for clock output only.
- clkout  output  NUM_CH  gated clocks.
- ack  output  NUM_CH  registered; 1 = channel clock guaranteed running.
- active  output  NUM_CH  registered; 1 = gate enable asserted (state WAKE, ON or DRAIN).

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all channels in OFF; ack=0; active=0; counters=0; gate enable=0. clkout is low unless te=1.
- Per-channel FSM states: OFF, WAKE, ON, DRAIN. Channels are fully independent.
- OFF:
  - req=1 -> WAKE; load counter with WAKE_CYC.
  - Enable register goes 1 on the same edge.
- WAKE:
  - Counter decrements each cycle.
  - When counter==0 -> ON; ack rises on that edge.
  - req→ack latency is WAKE_CYC+1 cycles. With WAKE_CYC=0, ack rises 1 cycle after the state leaves OFF.
  - WAKE is not abortable: if req drops during WAKE, the channel still enters ON, then proceeds per the ON rules.
- ON:
  - ack=1.
  - req=0 -> DRAIN; load counter with HYST_CYC; ack falls on the same edge.
  - If HYST_CYC=0: ON -> OFF directly; ack and enable fall together.
- DRAIN:
  - Enable stays 1; ack=0.
  - req=1 -> ON; ack rises next edge, no wake delay.
  - Otherwise decrement. Counter==0 with req=0 -> OFF; enable falls.
  - If req=1 and counter==0 in the same cycle, req wins -> ON.
- Gating cell: enable is captured by a latch transparent while clk is low; clkout = clk AND (latched_en OR te).
  - clkout never shows a runt pulse.
  - Enable changes take effect from the next rising clk edge.
- te=1: clkout = clk for all channels, including during rst. ack/active/FSM are unaffected by te.
- Reset mid-operation: every channel goes to OFF on the next edge regardless of state; the gate closes after the current high phase completes.
- Counters never wrap. Loads are saturating constants; decrement only when nonzero.

Decomposition:
- Package ctech_lib_clk_gate_pkg holds:
  - state enum typedef (OFF/WAKE/ON/DRAIN, 2 bits);
  - localparam helper checking CNT_W sufficiency.
- Sub-module ctech_lib_clk_gate_cell: single-channel low-transparent latch plus AND, ports clk, en, te, clkout. Instantiated NUM_CH times in a generate loop.
- FSM and counters stay in the top module as a per-channel generate block.

Test Plan:
- Reset: rst=1 for 3 cycles with req=all-ones, te=0 -> ack=0, active=0, clkout flat low. Release rst -> ack[0] rises exactly WAKE_CYC+1=3 cycles later.
- Hysteresis: ch1 ON, drop req[1] -> ack[1] falls next edge; clkout[1] keeps toggling for 8 cycles; active[1] falls on 9th edge; clkout[1] has no partial pulses.
- Re-request in DRAIN: drop req[2], reassert after 4 cycles -> ack[2] back to 1 on next edge; clkout[2] never stops.
- WAKE not abortable: req[3] pulse of 1 cycle -> channel passes WAKE (2 cycles), ON for 1 cycle with ack=1, DRAIN 8 cycles, then OFF.
- Corner configs: WAKE_CYC=0, HYST_CYC=0 -> ack rises 1 cycle after req; on req drop, ack and active fall together.
- Test enable: te=1 with all req=0 and with rst=1 -> all clkout equal clk; ack/active remain 0. te 1->0 -> clkout stops at a low phase, no glitch.

Source files
------------

// File: rtl/ctech_lib_clk_gate_pkg.sv
// Shared types and elaboration helpers for the multi-channel clock-gating controller.
package ctech_lib_clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } cg_state_e;

  function automatic bit cnt_w_ok(input int cnt_w, input int wake_cyc, input int hyst_cyc);
    int max_cyc;
    max_cyc = (wake_cyc > hyst_cyc) ? wake_cyc : hyst_cyc;
    return (cnt_w >= 31) || ((1 << cnt_w) > max_cyc);
  endfunction

  // Clamp a reload constant into the counter range so a load can never wrap.
  function automatic int sat_load(input int val, input int cnt_w);
    int max_val;
    max_val = (cnt_w >= 31) ? val : ((1 << cnt_w) - 1);
    if (val < 0) return 0;
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/ctech_lib_clk_gate_cell.sv
// Single-channel glitch-free clock gate: low-transparent enable latch followed by an AND.
module ctech_lib_clk_gate_cell (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic clkout
);

  logic r_en_lat;

  // Enable can only change while clk is low, so the AND never sees a mid-pulse edge.
  always_latch begin
    if (!clk) r_en_lat = en;
  end

  assign clkout = clk & (r_en_lat | te);

endmodule

// File: rtl/ctech_lib_clk_gate_ctrl.sv
// Multi-channel clock-gating controller with req/ack handshake, wake delay and idle hysteresis.
//
// state | meaning
// OFF   | gate closed, ack low
// WAKE  | gate open, counting down the wake delay before ack
// ON    | gate open, ack high
// DRAIN | gate open, ack low, counting idle cycles before closing
module ctech_lib_clk_gate_ctrl
  import ctech_lib_clk_gate_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WAKE_CYC = 2,
  parameter int HYST_CYC = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              te,
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] active
);

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(sat_load(WAKE_CYC, CNT_W));
  localparam logic [CNT_W-1:0] HYST_LD = CNT_W'(sat_load(HYST_CYC, CNT_W));

  if (!cnt_w_ok(CNT_W, WAKE_CYC, HYST_CYC) || NUM_CH < 1 || NUM_CH > 32) begin : g_bad_cfg
    $error("ctech_lib_clk_gate_ctrl: illegal NUM_CH or CNT_W too narrow for WAKE_CYC/HYST_CYC");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cg_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_en, w_en_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_OFF;
        r_cnt   <= '0;
        r_ack   <= 1'b0;
        r_en    <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_ack   <= w_ack_nxt;
        r_en    <= w_en_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = r_ack;
      w_en_nxt    = r_en;
      case (r_state)
        ST_OFF: begin
          if (req[g]) begin
            w_state_nxt = ST_WAKE;
            w_cnt_nxt   = WAKE_LD;
            w_en_nxt    = 1'b1;
            w_ack_nxt   = 1'b0;
          end
        end
        ST_WAKE: begin
          // Not abortable: req is ignored until the wake delay has elapsed.
          if (r_cnt == '0) begin
            w_state_nxt = ST_ON;
            w_ack_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        ST_ON: begin
          if (!req[g]) begin
            w_ack_nxt = 1'b0;
            if (HYST_LD == '0) begin
              w_state_nxt = ST_OFF;
              w_en_nxt    = 1'b0;
            end else begin
              w_state_nxt = ST_DRAIN;
              w_cnt_nxt   = HYST_LD;
            end
          end
        end
        ST_DRAIN: begin
          if (req[g]) begin
            w_state_nxt = ST_ON;
            w_ack_nxt   = 1'b1;
          end else if (r_cnt == '0) begin
            w_state_nxt = ST_OFF;
            w_en_nxt    = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_en_nxt    = 1'b0;
          w_ack_nxt   = 1'b0;
        end
      endcase
    end

    assign ack[g]    = r_ack;
    assign active[g] = r_en;

    ctech_lib_clk_gate_cell u_cell (
      .clk    (clk),
      .en     (r_en),
      .te     (te),
      .clkout (clkout[g])
    );
  end

endmodule

// File: tb/tb_ctech_lib_clk_gate_ctrl.sv
// Directed bench for the clock-gating controller: default config plus a zero-delay corner config.
`timescale 1ns/1ps
module tb_ctech_lib_clk_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       te;
  logic [3:0] req, clkout, ack, active;
  logic [1:0] req_b, clkout_b, ack_b, active_b;

  int n_chk    = 0;
  int n_err    = 0;
  int n_glitch = 0;

  always #5 clk = ~clk;

  ctech_lib_clk_gate_ctrl #(
    .NUM_CH(4), .WAKE_CYC(2), .HYST_CYC(8), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .te(te),
    .clkout(clkout), .ack(ack), .active(active)
  );

  ctech_lib_clk_gate_ctrl #(
    .NUM_CH(2), .WAKE_CYC(0), .HYST_CYC(0), .CNT_W(8)
  ) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .te(te),
    .clkout(clkout_b), .ack(ack_b), .active(active_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gated clocks may only rise with clk (t%10==5) and fall with clk (t%10==0).
  logic [5:0] cg_prev = '0;
  always @(clkout or clkout_b) begin
    logic [5:0] cur;
    cur = {clkout_b, clkout};
    for (int i = 0; i < 6; i++) begin
      if (cg_prev[i] === 1'b0 && cur[i] === 1'b1 && ($time % 10) != 5) n_glitch++;
      if (cg_prev[i] === 1'b1 && cur[i] === 1'b0 && ($time % 10) != 0) n_glitch++;
    end
    cg_prev = cur;
  end

  initial begin
    rst = 1'b1; te = 1'b0; req = 4'hF; req_b = 2'b00;

    // reset held 3 cycles with all requests high
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_clkout", clkout, 4'h0);
      chk("rst_ack",    ack,    4'h0);
      chk("rst_active", active, 4'h0);
    end
    rst = 1'b0;

    // wake latency WAKE_CYC+1
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wake_ack",    ack,    (k == 3) ? 4'hF : 4'h0);
      chk("wake_active", active, 4'hF);
      chk("wake_clkout", clkout, (k == 0) ? 4'h0 : 4'hF);
    end

    // hysteresis on ch1
    req = 4'b1101;
    tick();
    chk("hyst_ack_fall", ack,    4'b1101);
    chk("hyst_active",   active, 4'hF);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("hyst_active1", active[1], (k < 9) ? 1'b1 : 1'b0);
      chk("hyst_clkout1", clkout[1], 1'b1);
    end
    tick();
    chk("hyst_clkout1_off", clkout[1], 1'b0);
    chk("hyst_ack1_off",    ack[1],    1'b0);

    // re-request during DRAIN on ch2
    req = 4'b1001;
    tick();
    chk("drain_ack2",    ack[2],    1'b0);
    chk("drain_clkout2", clkout[2], 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("drain_ack2",    ack[2],    1'b0);
      chk("drain_active2", active[2], 1'b1);
      chk("drain_clkout2", clkout[2], 1'b1);
    end
    req = 4'b1101;
    tick();
    chk("rereq_ack2",    ack[2],    1'b1);
    chk("rereq_clkout2", clkout[2], 1'b1);
    chk("rereq_ch1_off", active[1], 1'b0);

    // ch3: drain to OFF, then a one-cycle request pulse
    req = 4'b0101;
    repeat (12) tick();
    chk("ch3_off_active", active[3], 1'b0);
    chk("ch3_off_ack",    ack[3],    1'b0);
    req = 4'b1101;
    tick();
    chk("pulse_active3", active[3], 1'b1);
    chk("pulse_ack3",    ack[3],    1'b0);
    req = 4'b0101;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("pulse_ack3",    ack[3],    (k == 3) ? 1'b1 : 1'b0);
      chk("pulse_active3", active[3], 1'b1);
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("pulse_drain3", active[3], (k < 9) ? 1'b1 : 1'b0);
    end

    // reset mid-operation with ch0/ch2 ON
    rst = 1'b1;
    tick();
    chk("midrst_ack",     ack,       4'h0);
    chk("midrst_active",  active,    4'h0);
    chk("midrst_clkout0", clkout[0], 1'b1);
    rst = 1'b0; req = 4'h0;
    tick();
    chk("midrst_clkout", clkout, 4'h0);
    chk("midrst_active", active, 4'h0);

    // corner config WAKE_CYC=0, HYST_CYC=0
    req_b = 2'b01;
    tick();
    chk("b_wake_active", active_b, 2'b01);
    chk("b_wake_ack",    ack_b,    2'b00);
    tick();
    chk("b_on_ack",      ack_b,    2'b01);
    chk("b_on_clkout",   clkout_b, 2'b01);
    req_b = 2'b00;
    tick();
    chk("b_off_ack",     ack_b,       2'b00);
    chk("b_off_active",  active_b,    2'b00);
    chk("b_off_clkout",  clkout_b[0], 1'b1);
    tick();
    chk("b_off_clkout2", clkout_b, 2'b00);

    // test enable
    @(negedge clk); #1;
    te = 1'b1;
    tick();
    chk("te_clkout",   clkout,   4'hF);
    chk("te_clkout_b", clkout_b, 2'b11);
    chk("te_ack",      ack,      4'h0);
    chk("te_active",   active,   4'h0);
    @(negedge clk); #1;
    chk("te_clkout_low", clkout, 4'h0);
    rst = 1'b1;
    tick();
    chk("te_rst_clkout", clkout, 4'hF);
    chk("te_rst_ack",    ack,    4'h0);
    chk("te_rst_active", active, 4'h0);
    @(negedge clk); #1;
    te = 1'b0;
    tick();
    chk("te_off_clkout",   clkout,   4'h0);
    chk("te_off_clkout_b", clkout_b, 2'b00);
    rst = 1'b0;
    tick();

    chk("no_glitch", n_glitch, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
